// File: rtl/conv_pool_stage.sv
// conv_pool_stage: qualifies the convolution datapath result by raster position,
// applies ReLU and 2x2/stride-2 max pooling, and emits pooled words as a
// valid-qualified stream with their raster index.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for start; no pixels counted
// STREAM | counting pixel_valid cycles; waits for index 0, aborts on a gap
// FLUSH  | two cycles draining the qualify and output stages after the last pixel
module conv_pool_stage #(
  parameter int DATA_WIDTH  = 16,
  parameter int KERNEL_SIZE = 5,
  parameter int IMAGE_SIZE  = 28,
  localparam int CONV_SIZE  = IMAGE_SIZE - KERNEL_SIZE + 1,
  localparam int POOL_SIZE  = CONV_SIZE / 2,
  localparam int IDX_W      = $clog2(POOL_SIZE * POOL_SIZE)
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  pixel_valid_i,
  input  logic [DATA_WIDTH-1:0] conv_in_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  output logic [IDX_W-1:0]      out_index_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  frame_error_o
);

  localparam int POS_W = $clog2(IMAGE_SIZE);
  localparam int CC_W  = $clog2(CONV_SIZE);
  localparam int LB_W  = $clog2(POOL_SIZE);

  localparam logic [POS_W-1:0] POS_LAST = POS_W'(IMAGE_SIZE - 1);
  localparam logic [POS_W-1:0] POS_KM1  = POS_W'(KERNEL_SIZE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(POOL_SIZE * POOL_SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STREAM = 2'd1,
    S_FLUSH  = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [POS_W-1:0]   row_q, row_d;
  logic [POS_W-1:0]   col_q, col_d;
  logic               flush_q, flush_d;
  logic               err_q, err_d;

  // Position of the pixel accepted this cycle and stream-control strobes.
  logic               accept;
  logic               gap;
  logic [POS_W-1:0]   pos_r;
  logic [POS_W-1:0]   pos_c;

  // Qualify stage: describes the conv result present on conv_in_i this cycle.
  logic               qv_q;
  logic [CC_W-1:0]    qcr_q;
  logic [CC_W-1:0]    qcc_q;

  logic signed [DATA_WIDTH-1:0] hold_q;
  logic signed [DATA_WIDTH-1:0] line_buf_q [POOL_SIZE];

  logic signed [DATA_WIDTH-1:0] relu_v;
  logic signed [DATA_WIDTH-1:0] pool_h;
  logic signed [DATA_WIDTH-1:0] line_rd;
  logic signed [DATA_WIDTH-1:0] pool_m;
  logic [LB_W-1:0]              lb_idx;
  logic [IDX_W-1:0]             pool_idx;
  logic                         emit;

  logic signed [DATA_WIDTH-1:0] out_data_q;
  logic                         out_valid_q;
  logic [IDX_W-1:0]             out_index_q;
  logic                         frame_done_q;

  // Frame control state register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      flush_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      flush_q <= flush_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic: raster counting, gap detection and flush sequencing.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    flush_d = flush_q;
    err_d   = err_q;
    accept  = 1'b0;
    gap     = 1'b0;
    pos_r   = row_q;
    pos_c   = col_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          err_d   = 1'b0;
          row_d   = '0;
          col_d   = '0;
          flush_d = 1'b0;
          state_d = S_STREAM;
          if (pixel_valid_i) begin
            // Start and pixel 0 in the same cycle.
            accept = 1'b1;
            pos_r  = '0;
            pos_c  = '0;
            col_d  = POS_W'(1);
          end
        end
      end
      S_STREAM: begin
        if (pixel_valid_i) begin
          accept = 1'b1;
          if (col_q == POS_LAST) begin
            col_d = '0;
            if (row_q == POS_LAST) begin
              state_d = S_FLUSH;
              flush_d = 1'b0;
            end else begin
              row_d = row_q + POS_W'(1);
            end
          end else begin
            col_d = col_q + POS_W'(1);
          end
        end else if ((row_q != '0) || (col_q != '0)) begin
          // Position (0,0) means pixel 0 not yet seen, so a low pixel_valid is a wait.
          gap     = 1'b1;
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      S_FLUSH: begin
        if (flush_q) begin
          state_d = S_IDLE;
        end else begin
          flush_d = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Qualify stage: tag next cycle's conv_in with its conv coordinates.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      qv_q  <= 1'b0;
      qcr_q <= '0;
      qcc_q <= '0;
    end else begin
      qv_q  <= accept && (pos_r >= POS_KM1) && (pos_c >= POS_KM1);
      qcr_q <= CC_W'(pos_r - POS_KM1);
      qcc_q <= CC_W'(pos_c - POS_KM1);
    end
  end

  // ReLU and the two-level max tree for the pool window.
  always_comb begin
    relu_v   = conv_in_i[DATA_WIDTH-1] ? '0 : $signed(conv_in_i);
    pool_h   = (relu_v > hold_q) ? relu_v : hold_q;
    lb_idx   = qcc_q[CC_W-1:1];
    line_rd  = line_buf_q[lb_idx];
    pool_m   = (line_rd > pool_h) ? line_rd : pool_h;
    pool_idx = IDX_W'(qcr_q[CC_W-1:1]) * IDX_W'(POOL_SIZE) + IDX_W'(lb_idx);
    // A result still in flight when the stream breaks belongs to the discarded frame.
    emit     = qv_q && qcc_q[0] && qcr_q[0] && !gap;
  end

  // Horizontal pair holding register and the per-pool-column line buffer.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      hold_q <= '0;
      for (int i = 0; i < POOL_SIZE; i++) begin
        line_buf_q[i] <= '0;
      end
    end else if (qv_q) begin
      if (!qcc_q[0]) begin
        hold_q <= relu_v;
      end else if (!qcr_q[0]) begin
        line_buf_q[lb_idx] <= pool_h;
      end
    end
  end

  // Output register: data and index hold between strobes.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_index_q  <= '0;
      frame_done_q <= 1'b0;
    end else begin
      out_valid_q  <= emit;
      frame_done_q <= emit && (pool_idx == IDX_LAST);
      if (emit) begin
        out_data_q  <= pool_m;
        out_index_q <= pool_idx;
      end
    end
  end

  assign out_data_o    = out_data_q;
  assign out_valid_o   = out_valid_q;
  assign out_index_o   = out_index_q;
  assign frame_done_o  = frame_done_q;
  assign frame_error_o = err_q;
  // The last output lands in the second flush cycle, where busy is already released.
  assign busy_o        = (state_q != S_IDLE) && !frame_done_q;

endmodule

// File: tb/tb_conv_pool_stage.sv
// Scoreboard bench for conv_pool_stage: stimulus pushes hand-derived pooled
// results (index, value, done flag, arrival cycle); a monitor pops on out_valid.
module tb_conv_pool_stage;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        start_i = 1'b0;
  logic        pixel_valid_i = 1'b0;
  logic [15:0] conv_in_i = 16'h0000;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic [7:0]  out_index_o;
  logic        busy_o;
  logic        frame_done_o;
  logic        frame_error_o;

  conv_pool_stage #(
    .DATA_WIDTH(16),
    .KERNEL_SIZE(5),
    .IMAGE_SIZE(28)
  ) dut (
    .clk_i(clk_i),
    .reset_i(reset_i),
    .start_i(start_i),
    .pixel_valid_i(pixel_valid_i),
    .conv_in_i(conv_in_i),
    .out_data_o(out_data_o),
    .out_valid_o(out_valid_o),
    .out_index_o(out_index_o),
    .busy_o(busy_o),
    .frame_done_o(frame_done_o),
    .frame_error_o(frame_error_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  typedef struct {
    int idx;
    int data;
    bit done;
    int at_cyc;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  int   last_done_cyc = -1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every out_valid must match the oldest expected result.
  always @(negedge clk_i) begin
    exp_t e;
    if (!reset_i) begin
      if (out_valid_o) begin
        if (sb.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("out_index", int'(out_index_o), e.idx);
          chk("out_data", int'(out_data_o), e.data);
          chk("frame_done", int'(frame_done_o), int'(e.done));
          chk("out_cycle", cyc, e.at_cyc);
        end
      end else if (frame_done_o) begin
        chk("done_without_valid", 1, 0);
      end
      if (frame_done_o) begin
        chk("busy_at_done", int'(busy_o), 0);
        last_done_cyc = cyc;
      end
    end
  end

  task automatic drive_cycle(input bit st, input bit pv, input logic [15:0] cv);
    @(posedge clk_i);
    #1;
    start_i       = st;
    pixel_valid_i = pv;
    conv_in_i     = cv;
  endtask

  // Conv value the datapath would present for the window ending at (r,c).
  function automatic logic [15:0] conv_for(input int mode, input int r, input int c);
    int cr;
    int cc;
    cr = r - 4;
    cc = c - 4;
    if (mode == 0) return 16'd3;
    if (mode == 1) return 16'hFFFB;
    if (cr < 0 || cc < 0) return 16'h7FFF;
    if (mode == 2) return 16'(cr * 24 + cc);
    if (cr == 0 && cc == 0) return 16'hFFFF;
    if ((cr == 0 && cc == 1) || (cr == 1 && cc == 0)) return 16'd7;
    if (cr == 1 && cc == 1) return 16'hFFFE;
    return 16'd0;
  endfunction

  function automatic int exp_val(input int mode, input int pr, input int pc);
    case (mode)
      0: return 3;
      1: return 0;
      2: return (2 * pr + 1) * 24 + 2 * pc + 1;
      default: return (pr == 0 && pc == 0) ? 7 : 0;
    endcase
  endfunction

  task automatic check_reset_outputs(input string nm);
    chk(nm, int'({out_valid_o, out_data_o, out_index_o, busy_o, frame_done_o, frame_error_o}), 0);
  endtask

  // stop_at < 0: full frame; otherwise stop at that pixel with a gap or a reset.
  task automatic run_frame(input int mode, input int pre_wait, input int stop_at,
                           input bit stop_rst, input bit start_mid, output int first_cyc);
    logic [15:0] cv;
    int r, c, cr, cc, idx;
    exp_t e;
    cv = 16'h7FFF;
    first_cyc = -1;
    for (int w = 0; w < pre_wait; w++) drive_cycle(w == 0, 1'b0, 16'h7FFF);
    for (int p = 0; p < 784; p++) begin
      if (p == stop_at) break;
      drive_cycle((pre_wait == 0 && p == 0) || (start_mid && p == 400), 1'b1, cv);
      if (p == 0) first_cyc = cyc;
      if (p == 1) chk("busy_streaming", int'(busy_o), 1);
      r = p / 28;
      c = p % 28;
      cr = r - 4;
      cc = c - 4;
      if (cr >= 0 && cc >= 0 && (cr % 2) == 1 && (cc % 2) == 1) begin
        idx = (cr / 2) * 12 + cc / 2;
        e = '{idx, exp_val(mode, cr / 2, cc / 2), (idx == 143), cyc + 2};
        sb.push_back(e);
      end
      cv = conv_for(mode, r, c);
    end
    if (stop_at < 0) begin
      drive_cycle(1'b0, 1'b0, cv);
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 16'h7FFF);
      chk("scoreboard_drained", sb.size(), 0);
      chk("busy_after_frame", int'(busy_o), 0);
    end else if (!stop_rst) begin
      drive_cycle(1'b0, 1'b0, cv);
      @(posedge clk_i);
      #1;
      chk("gap_frame_error", int'(frame_error_o), 1);
      chk("gap_busy", int'(busy_o), 0);
      for (int i = 0; i < 6; i++) drive_cycle(1'b0, 1'b0, 16'h7FFF);
      chk("gap_no_pending", sb.size(), 0);
      chk("gap_error_sticky", int'(frame_error_o), 1);
    end else begin
      @(posedge clk_i);
      #1;
      reset_i       = 1'b1;
      start_i       = 1'b0;
      pixel_valid_i = 1'b0;
      conv_in_i     = 16'h7FFF;
      sb.delete();
      for (int i = 0; i < 3; i++) begin
        @(negedge clk_i);
        check_reset_outputs("midframe_reset_outputs");
      end
      @(posedge clk_i);
      #1;
      reset_i = 1'b0;
      for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 16'h7FFF);
      chk("post_reset_idle", int'({out_valid_o, busy_o, frame_done_o}), 0);
    end
  endtask

  initial begin
    int f;
    reset_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_reset_outputs("reset_outputs");
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    // Constant 3, start one cycle ahead of pixel 0.
    run_frame(0, 1, -1, 1'b0, 1'b0, f);
    chk("t1_done_offset", last_done_cyc - f, 785);
    chk("t1_frame_error", int'(frame_error_o), 0);

    // Constant -5 with a legal wait before pixel 0.
    run_frame(1, 3, -1, 1'b0, 1'b0, f);
    chk("t2_frame_error", int'(frame_error_o), 0);

    // Ramp, start and pixel 0 together.
    run_frame(2, 0, -1, 1'b0, 1'b0, f);
    chk("t3_done_offset", last_done_cyc - f, 785);

    // Single non-trivial window with negatives.
    run_frame(3, 1, -1, 1'b0, 1'b0, f);

    // Stream gap at pixel 300, then a clean ramp frame.
    run_frame(2, 1, 300, 1'b0, 1'b0, f);
    run_frame(2, 1, -1, 1'b0, 1'b0, f);
    chk("t5_error_cleared", int'(frame_error_o), 0);

    // Reset at pixel 500, then a ramp frame with a stray start mid-stream.
    run_frame(2, 1, 500, 1'b1, 1'b0, f);
    run_frame(2, 1, -1, 1'b0, 1'b1, f);
    chk("t6_done_offset", last_done_cyc - f, 785);
    chk("t6_frame_error", int'(frame_error_o), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/conv_pool_stage.md
Name: conv_pool_stage

Overview:
Downstream stage of the convolution datapath. It tracks the raster position of the pixel stream feeding the datapath and uses it to qualify the datapath's combinational conv result. Valid results pass through ReLU and 2x2/stride-2 max pooling, and pooled words are emitted as a valid-qualified stream for the next layer's buffer.

Parameters:
DATA_WIDTH, 16, signed word width of conv_in and out_data (same fixed-point format as datapath).
KERNEL_SIZE, 5, convolution kernel edge; must match the datapath.
IMAGE_SIZE, 28, input image edge; must match the datapath.
Derived, not overridable:
- CONV_SIZE = IMAGE_SIZE-KERNEL_SIZE+1 (24); must be even.
- POOL_SIZE = CONV_SIZE/2 (12).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high; clears all state.
start  in  1  one-cycle pulse; arms a new frame. The first pixel_valid may be in the same or a later cycle.
pixel_valid  in  1  high in each cycle a pixel is driven onto the datapath pixel_input; must stay high for IMAGE_SIZE^2 consecutive cycles.
conv_in  in  DATA_WIDTH  datapath add_result, signed.
out_data  out  DATA_WIDTH  pooled result, signed, always >= 0.
out_valid  out  1  one-cycle strobe qualifying out_data; no backpressure.
out_index  out  clog2(POOL_SIZE^2)  raster index pr*POOL_SIZE+pc of out_data.
busy  out  1  high from start until frame_done or abort.
frame_done  out  1  one-cycle pulse, coincident with the last out_valid.
frame_error  out  1  sticky; set on a stream gap; cleared by start or reset.

Behaviour:
Reset:
- All outputs are 0.
- FSM is IDLE; counters and line buffer are cleared.

FSM:
- IDLE -> STREAM on start (frame_error cleared; row/col counters zeroed).
- STREAM counts pixel_valid cycles: col 0..IMAGE_SIZE-1, then row increments. The first pixel_valid after start is index 0.
- STREAM -> FLUSH after pixel IMAGE_SIZE^2-1 is accepted.
- FLUSH lasts 2 cycles to drain the pipeline, then -> IDLE.
- start outside IDLE is ignored.
- In STREAM, pixel_valid low after index 0 sets frame_error, drops busy and returns to IDLE. No further out_valid is emitted for that frame; partial pool state is discarded.
- Before index 0, pixel_valid low is a legal wait and does not set frame_error.

Qualification:
- A pixel accepted at cycle t with position (r,c) makes conv_in at cycle t+1 the conv result for the window whose bottom-right corner is (r,c).
- That result is valid iff r>=KERNEL_SIZE-1 and c>=KERNEL_SIZE-1.
- Conv coordinates are cr=r-(KERNEL_SIZE-1), cc=c-(KERNEL_SIZE-1).
- Invalid positions, including row wrap windows and pre-frame garbage, are ignored.

ReLU:
- v = 0 if conv_in[MSB] is set, else conv_in.
- No width change and no saturation.

Pooling (signed compares; ties keep either value, which is numerically identical):
- cc even: hold_reg <= v.
- cc odd: h = max(hold_reg, v).
  - cr even: line_buf[cc/2] <= h.
  - cr odd: out_data <= max(line_buf[cc/2], h), out_valid <= 1, out_index <= (cr/2)*POOL_SIZE+cc/2.
- line_buf is POOL_SIZE x DATA_WIDTH registers. Each entry is written before it is read and needs no clear between frames.

Latency:
- out_valid asserts 2 cycles after the pixel that completes the pool window is accepted (qualify stage + output register).
- out_data and out_index hold their values until the next out_valid.
- frame_done pulses together with out_index = POOL_SIZE^2-1 in FLUSH; busy falls in the same cycle.

Reset mid-frame:
- Everything returns to reset values immediately.
- No out_valid or frame_done until a new start.

Test Plan:
1. reset, start, then 784 consecutive pixel_valid with conv_in = 3 -> 144 out_valid, all out_data = 3, out_index 0..143 in order. First out_valid is 147 cycles after the first pixel_valid (pixel 145 plus 2); frame_done is at cycle 785.
2. conv_in = -5 constant for a full frame -> 144 outputs, all 0. frame_error = 0.
3. conv_in driven as cr*24+cc at valid positions (don't-care elsewhere, drive 0x7FFF) -> out(pr,pc) = (2pr+1)*24+2pc+1, e.g. index 0 = 25, index 143 = 575. The 0x7FFF values never appear.
4. Window cr0/cr1, cc0/cc1 = {-1, 7, 7, -2}, all other values 0 -> out_index 0 = 7.
5. pixel_valid deasserted at pixel index 300 -> frame_error = 1 and busy = 0 the next cycle. No out_valid after it, no frame_done. A new start then a clean frame gives correct results with frame_error = 0.
6. reset asserted at pixel 500, released, start plus full ramp frame -> all outputs reset to 0 while reset is high. The next frame matches scenario 3 exactly, and a start pulsed during STREAM has no effect.
